// File: rtl/scan_priority_encoder.sv
// Sequential priority encoder: streams the index of every set bit of an accepted request vector.
// Optional build macro SCAN_MSB_FIRST_EN scans from the highest set bit down.
module scan_priority_encoder #(
  parameter int unsigned N    = 8,
  parameter int unsigned IDXW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last,
  output logic            out_zero,
  output logic            busy
);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  localparam logic [N-1:0] One = {{(N-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [N-1:0]    pend_q, pend_d;

  logic            scan;
  logic [IDXW-1:0] idx_raw;
  logic [N-1:0]    sel_mask;
  logic [N-1:0]    pend_clr;
  logic            last_raw;
  logic            zero_raw;
  logic            accept;
  logic            beat;

  assign scan = (state_q == StScan);

  // Select the bit this beat reports; the final assignment in the loop wins.
  always_comb begin
    idx_raw = '0;
`ifdef SCAN_MSB_FIRST_EN
    for (int i = 0; i < int'(N); i++) begin
      if (pend_q[i]) idx_raw = IDXW'(i);
    end
`else
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (pend_q[i]) idx_raw = IDXW'(i);
    end
`endif
  end

  assign sel_mask = One << idx_raw;
  assign pend_clr = pend_q & ~sel_mask;
  // At most one bit set means this is the final beat.
  assign last_raw = ((pend_q & (pend_q - One)) == '0);
  assign zero_raw = (pend_q == '0);

  assign out_valid = scan;
  assign out_idx   = scan ? idx_raw : '0;
  assign out_last  = scan & last_raw;
  assign out_zero  = scan & zero_raw;
  assign busy      = scan;

  assign beat     = out_valid & out_ready;
  assign in_ready = ~scan | (beat & last_raw);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          pend_d  = in_vec;
          state_d = StScan;
        end
      end
      StScan: begin
        if (beat) begin
          if (last_raw) begin
            if (accept) begin
              pend_d = in_vec;
            end else begin
              pend_d  = '0;
              state_d = StIdle;
            end
          end else begin
            pend_d = pend_clr;
          end
        end
      end
      default: begin
        state_d = StIdle;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_scan_priority_encoder.sv
// Directed self-checking bench for scan_priority_encoder (N=8); honours SCAN_MSB_FIRST_EN.
module tb_scan_priority_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       out_zero;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  scan_priority_encoder #(.N(8), .IDXW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a vector for one cycle; returns at the negedge where its first beat is visible.
  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Check the current beat, then advance one cycle.
  task automatic beat_chk(input string tag, input logic [2:0] idx, input logic last,
                          input logic zero);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".idx"},   32'(out_idx),   32'(idx));
    check({tag, ".last"},  32'(out_last),  32'(last));
    check({tag, ".zero"},  32'(out_zero),  32'(zero));
    @(negedge clk);
  endtask

  task automatic idle_chk(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'd0);
    check({tag, ".ready"}, 32'(in_ready),  32'd1);
    check({tag, ".busy"},  32'(busy),      32'd0);
  endtask

  logic [2:0] a5_seq [4];
  logic [2:0] c0_first, c0_second, b2b_first, b2b_second;

  initial begin
`ifdef SCAN_MSB_FIRST_EN
    a5_seq    = '{3'd7, 3'd5, 3'd2, 3'd0};
    c0_first  = 3'd7; c0_second  = 3'd6;
    b2b_first = 3'd1; b2b_second = 3'd0;
`else
    a5_seq    = '{3'd0, 3'd2, 3'd5, 3'd7};
    c0_first  = 3'd6; c0_second  = 3'd7;
    b2b_first = 3'd0; b2b_second = 3'd1;
`endif
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    idle_chk("rst");
    check("rst.idx",  32'(out_idx),  32'd0);
    check("rst.last", 32'(out_last), 32'd0);
    check("rst.zero", 32'(out_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    idle_chk("rel");

    // One-hot walk
    for (int i = 0; i < 8; i++) begin
      send(8'(1 << i));
      beat_chk($sformatf("onehot%0d", i), 3'(i), 1'b1, 1'b0);
      idle_chk($sformatf("onehot%0d.after", i));
    end

    // Mixed pattern A5
    send(8'hA5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("a5.%0d.busy", i), 32'(busy), 32'd1);
      beat_chk($sformatf("a5.%0d", i), a5_seq[i], (i == 3), 1'b0);
    end
    idle_chk("a5.after");

    // Zero vector
    send(8'h00);
    beat_chk("zero", 3'd0, 1'b1, 1'b1);
    idle_chk("zero.after");

    // Backpressure; in_vec wiggles while not ready and must be ignored
    out_ready = 1'b0;
    send(8'hC0);
    for (int i = 0; i < 3; i++) begin
      in_vec = 8'(8'h11 << i);
      check($sformatf("bp%0d.ready", i), 32'(in_ready), 32'd0);
      beat_chk($sformatf("bp%0d", i), c0_first, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    beat_chk("bp.first", c0_first, 1'b0, 1'b0);
    beat_chk("bp.second", c0_second, 1'b1, 1'b0);
    idle_chk("bp.after");

    // Back-to-back vectors, no bubble
    in_valid = 1'b1;
    in_vec   = 8'h03;
    @(negedge clk);
    check("b2b.0.ready", 32'(in_ready), 32'd0);
    in_vec = 8'h80;
    beat_chk("b2b.0", b2b_first, 1'b0, 1'b0);
    check("b2b.1.ready", 32'(in_ready), 32'd1);
    beat_chk("b2b.1", b2b_second, 1'b1, 1'b0);
    in_valid = 1'b0;
    check("b2b.2.ready", 32'(in_ready), 32'd1);
    beat_chk("b2b.2", 3'd7, 1'b1, 1'b0);
    idle_chk("b2b.after");

    // Asynchronous reset mid-scan
    send(8'hFF);
`ifdef SCAN_MSB_FIRST_EN
    check("arst.first.idx", 32'(out_idx), 32'd7);
`else
    check("arst.first.idx", 32'(out_idx), 32'd0);
`endif
    @(posedge clk);
    #2;
    check("arst.mid.valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(out_valid), 32'd0);
    check("arst.busy",  32'(busy),      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_chk($sformatf("arst.post%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
